// File: rtl/iob_timer_arb.sv
// iob_timer_arb: round-robin front end that shares one iob_timer among N_REQ requesters.
// Optional macro IOB_TIMER_ARB_TIMEOUT_EN adds an access timeout with an error flag.
module iob_timer_arb #(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ-1:0]         cmd,
   output logic [N_REQ-1:0]         ack,
   output logic [63:0]              data_o,
   output logic                     err,
   output logic [$clog2(N_REQ)-1:0] gnt_id,
   output logic                     busy,
   output logic                     t_valid,
   output logic [1:0]               t_addr,
   output logic [31:0]              t_wdata,
   input  logic [31:0]              t_rdata,
   input  logic                     t_ready
);

   localparam int IW = $clog2(N_REQ);

   // Timer register map, mirrors the TIMER_* codes of iob_timer.vh
   localparam logic [1:0] TIMER_RESET     = 2'd0;
   localparam logic [1:0] TIMER_STOP      = 2'd1;
   localparam logic [1:0] TIMER_DATA_LOW  = 2'd2;
   localparam logic [1:0] TIMER_DATA_HIGH = 2'd3;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_STOP = 3'd1;
   localparam logic [2:0] S_GAP1 = 3'd2;
   localparam logic [2:0] S_RDLO = 3'd3;
   localparam logic [2:0] S_GAP2 = 3'd4;
   localparam logic [2:0] S_RDHI = 3'd5;
   localparam logic [2:0] S_RST  = 3'd6;
   localparam logic [2:0] S_DONE = 3'd7;

   if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("iob_timer_arb: N_REQ must be 2..16 and TIMEOUT_CYC >= 1");
   end

   logic [2:0]    r_state;
   logic [2:0]    w_next;
   logic [IW-1:0] r_rr;
   logic [IW-1:0] r_gnt;
   logic [IW-1:0] w_win;
   logic [IW-1:0] w_idx;
   logic [IW-1:0] w_rr_nxt;
   logic          w_found;
   logic          w_grant;
   logic          w_acc;
   logic          w_tmo;
   logic [63:0]   r_data;

   // Round-robin search: first set request at or after the pointer, wrapping
   always_comb begin
      w_found = 1'b0;
      w_win   = r_rr;
      w_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_idx = IW'((int'(r_rr) + i) % N_REQ);
         if (!w_found && req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   assign w_rr_nxt = (w_win == IW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
   assign w_grant  = (r_state == S_IDLE) && w_found;

   // Access states drive the timer; the GAP states let the lagging ready settle
   assign w_acc = (r_state == S_STOP) || (r_state == S_RDLO) ||
                  (r_state == S_RDHI) || (r_state == S_RST);

   // Sequencer next-state decision
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_found) w_next = cmd[w_win] ? S_RST : S_STOP;
         S_STOP:  if (t_ready) w_next = S_GAP1;
         S_GAP1:  w_next = S_RDLO;
         S_RDLO:  if (t_ready) w_next = S_GAP2;
         S_GAP2:  w_next = S_RDHI;
         S_RDHI:  if (t_ready) w_next = S_DONE;
         S_RST:   if (t_ready) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (w_tmo) w_next = S_DONE;
   end

   // State, grant bookkeeping and 64-bit count capture
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_rr    <= '0;
         r_gnt   <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_next;
         if (w_grant) begin
            r_gnt <= w_win;
            r_rr  <= w_rr_nxt;
         end
         if (r_state == S_RDLO && t_ready) r_data[31:0]  <= t_rdata;
         if (r_state == S_RDHI && t_ready) r_data[63:32] <= t_rdata;
         if (w_tmo) r_data <= '0;
      end
   end

`ifdef IOB_TIMER_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] r_to;
   logic          r_err;

   assign w_tmo = w_acc && !t_ready && (r_to == TW'(TIMEOUT_CYC - 1));

   // Wait counter per access; err is raised with the ack and dropped at the next grant
   always_ff @(posedge clk) begin
      if (rst) begin
         r_to  <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_acc && !t_ready && !w_tmo) r_to <= r_to + 1'b1;
         else                             r_to <= '0;
         if (w_tmo)        r_err <= 1'b1;
         else if (w_grant) r_err <= 1'b0;
      end
   end

   assign err = r_err;
`else
   assign w_tmo = 1'b0;
   assign err   = 1'b0;
`endif

   // Timer bus and completion pulse decoded from the current state
   always_comb begin
      t_valid = w_acc;
      t_addr  = TIMER_RESET;
      t_wdata = 32'd0;
      ack     = '0;
      case (r_state)
         S_STOP: t_addr = TIMER_STOP;
         S_RDLO: t_addr = TIMER_DATA_LOW;
         S_RDHI: t_addr = TIMER_DATA_HIGH;
         S_RST: begin
            t_addr  = TIMER_RESET;
            t_wdata = 32'd1;
         end
         S_DONE: ack[r_gnt] = 1'b1;
         default: ;
      endcase
   end

   assign data_o = r_data;
   assign gnt_id = r_gnt;
   assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_iob_timer_arb.sv
// tb_iob_timer_arb: directed bench for iob_timer_arb with a small timer model.
// The model counts, freezes on STOP, clears and runs on RESET, ready lags valid.
module tb_iob_timer_arb;

   localparam int N = 4;
   localparam logic [1:0] A_RST  = 2'd0;
   localparam logic [1:0] A_STOP = 2'd1;
   localparam logic [1:0] A_LO   = 2'd2;
   localparam logic [1:0] A_HI   = 2'd3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req = '0;
   logic [N-1:0]  cmd = '0;
   logic [N-1:0]  ack;
   logic [63:0]   data_o;
   logic          err;
   logic [1:0]    gnt_id;
   logic          busy;
   logic          t_valid;
   logic [1:0]    t_addr;
   logic [31:0]   t_wdata;
   logic [31:0]   t_rdata;
   logic          t_ready = 1'b0;

   int n_run  = 0;
   int n_fail = 0;

   logic [63:0] s_cnt   = '0;
   logic        s_run   = 1'b0;
   logic        dead    = 1'b0;
   logic        preload = 1'b0;
   logic [63:0] pre_val = '0;
   logic [1:0]  log_a [0:255];
   logic [31:0] log_w [0:255];
   int          n_log = 0;

   always #5 clk = ~clk;

   iob_timer_arb #(.N_REQ(N), .TIMEOUT_CYC(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .cmd     (cmd),
      .ack     (ack),
      .data_o  (data_o),
      .err     (err),
      .gnt_id  (gnt_id),
      .busy    (busy),
      .t_valid (t_valid),
      .t_addr  (t_addr),
      .t_wdata (t_wdata),
      .t_rdata (t_rdata),
      .t_ready (t_ready)
   );

   // Timer model and access log
   always @(posedge clk) begin
      if (rst) t_ready <= 1'b0;
      else     t_ready <= t_valid & ~dead;
      if (preload) begin
         s_cnt <= pre_val;
         s_run <= 1'b0;
      end else if (t_valid && t_ready && t_addr == A_RST && t_wdata[0]) begin
         s_cnt <= '0;
         s_run <= 1'b1;
      end else if (t_valid && t_ready && t_addr == A_STOP) begin
         s_run <= 1'b0;
      end else if (s_run) begin
         s_cnt <= s_cnt + 64'd1;
      end
      if (t_valid && t_ready) begin
         log_a[n_log[7:0]] <= t_addr;
         log_w[n_log[7:0]] <= t_wdata;
         n_log <= n_log + 1;
      end
   end

   assign t_rdata = (t_addr == A_LO) ? s_cnt[31:0] :
                    (t_addr == A_HI) ? s_cnt[63:32] : 32'd0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   logic [31:0]  r_vm;
   logic [31:0]  r_am;
   logic [N-1:0] r_ack;
   logic [63:0]  r_dat;
   logic         r_err;
   int           r_lat;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      cmd = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Issue one request and record valid/ack per cycle after the grant cycle
   task automatic seq(input int id, input logic c, input int ncyc);
      r_vm  = '0;
      r_am  = '0;
      r_ack = '0;
      r_dat = '0;
      r_err = 1'b0;
      r_lat = -1;
      req[id] = 1'b1;
      cmd[id] = c;
      for (int k = 1; k <= ncyc; k++) begin
         step();
         if (t_valid) r_vm[k] = 1'b1;
         if (ack != '0) begin
            r_am[k] = 1'b1;
            if (r_lat < 0) begin
               r_lat = k;
               r_ack = ack;
               r_dat = data_o;
               r_err = err;
            end
            req[id] = 1'b0;
         end
      end
   endtask

   logic [N-1:0] fa [0:4];
   int           fc [0:4];
   int           got;
   int           base;

   initial begin
      do_reset();
      chk("rst_ack", ack, 0);
      chk("rst_data", data_o, 0);
      chk("rst_err", err, 0);
      chk("rst_gnt", gnt_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tvld", t_valid, 0);
      chk("rst_taddr", t_addr, 0);
      chk("rst_twd", t_wdata, 0);

      pre_val = 64'h0123456789ABCDEF;
      preload = 1'b1;
      step();
      preload = 1'b0;
      base = n_log;
      seq(0, 1'b0, 12);
      chk("s_vld", r_vm, 32'h1B6);
      chk("s_ack_t", r_am, 32'h200);
      chk("s_ack", r_ack, 4'b0001);
      chk("s_data", r_dat, 64'h0123456789ABCDEF);
      chk("s_err", r_err, 0);
      chk("s_nacc", n_log - base, 3);
      chk("s_a0", log_a[base], A_STOP);
      chk("s_a1", log_a[base+1], A_LO);
      chk("s_a2", log_a[base+2], A_HI);

      base = n_log;
      seq(2, 1'b1, 6);
      chk("r_vld", r_vm, 32'h6);
      chk("r_ack_t", r_am, 32'h8);
      chk("r_ack", r_ack, 4'b0100);
      chk("r_gnt", gnt_id, 2);
      chk("r_nacc", n_log - base, 1);
      chk("r_addr", log_a[base], A_RST);
      chk("r_wd", log_w[base], 1);
      seq(0, 1'b0, 12);
      chk("r_ack2", r_ack, 4'b0001);
      chk("r_small", r_dat < 64'd20, 1);

      do_reset();
      req = 4'hF;
      got = 0;
      for (int k = 1; k <= 60 && got < 5; k++) begin
         step();
         if (ack != '0) begin
            fa[got] = ack;
            fc[got] = k;
            got++;
         end
      end
      req = '0;
      step();
      chk("f_cnt", got, 5);
      chk("f_a0", fa[0], 4'b0001);
      chk("f_a1", fa[1], 4'b0010);
      chk("f_a2", fa[2], 4'b0100);
      chk("f_a3", fa[3], 4'b1000);
      chk("f_a4", fa[4], 4'b0001);
      for (int i = 1; i < 5; i++) chk("f_gap", fc[i] - fc[i-1], 10);

      seq(3, 1'b0, 12);
      chk("w_g3", r_ack, 4'b1000);
      req = 4'b1001;
      got = 0;
      for (int k = 1; k <= 30 && got < 2; k++) begin
         step();
         if (ack != '0) begin
            fa[got] = ack;
            req = req & ~ack;
            got++;
         end
      end
      req = '0;
      step();
      chk("w_cnt", got, 2);
      chk("w_a0", fa[0], 4'b0001);
      chk("w_a1", fa[1], 4'b1000);

      req[2] = 1'b1;
      cmd[2] = 1'b0;
      repeat (4) step();
      chk("m_rdlo", {t_valid, t_addr}, {1'b1, A_LO});
      rst = 1'b1;
      req = '0;
      step();
      chk("m_vld", t_valid, 0);
      chk("m_busy", busy, 0);
      chk("m_ack", ack, 0);
      rst = 1'b0;
      seq(1, 1'b0, 12);
      chk("m_ack1", r_ack, 4'b0010);
      chk("m_lat", r_am, 32'h200);
      chk("m_gnt", gnt_id, 1);

      dead = 1'b1;
`ifdef IOB_TIMER_ARB_TIMEOUT_EN
      seq(0, 1'b0, 20);
      chk("t_vld", r_vm, 32'h0001FFFE);
      chk("t_ack_t", r_am, 32'h00020000);
      chk("t_ack", r_ack, 4'b0001);
      chk("t_err", r_err, 1);
      chk("t_data", r_dat, 0);
      dead = 1'b0;
      seq(1, 1'b0, 12);
      chk("t_ack2", r_ack, 4'b0010);
      chk("t_errclr", r_err, 0);
`else
      seq(0, 1'b0, 30);
      chk("h_busy", busy, 1);
      chk("h_noack", r_am, 0);
      chk("h_err", err, 0);
      do_reset();
      dead = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
